// File: rtl/mux_nto1_arb.sv
// N-to-1 registered selector with valid/ready handshake.
// Channels are picked either by a fixed index or by a round-robin scan.
module mux_nto1_arb #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data_i,
    input  logic [N-1:0]       in_valid_i,
    output logic [N-1:0]       in_ready_o,
    input  logic               mode_i,
    input  logic [SELW-1:0]    sel_i,
    output logic [WIDTH-1:0]   out_data_o,
    output logic [SELW-1:0]    out_chan_o,
    output logic               out_valid_o,
    input  logic               out_ready_i
);

    logic [WIDTH-1:0] chan_data [N];
    logic [N-1:0]     grant;
    logic [SELW-1:0]  grant_idx;
    logic             any_grant;
    logic             load;
    logic [WIDTH-1:0] sel_data;
    int               scan_idx;
    logic             scan_found;

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_chan_q,  out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;

    for (genvar gi = 0; gi < N; gi++) begin : g_split
        assign chan_data[gi] = in_data_i[gi*WIDTH +: WIDTH];
    end

    // The register can take a new word when empty or when it drains this cycle.
    assign load = !out_valid_q || out_ready_i;

    always_comb begin
        grant      = '0;
        grant_idx  = '0;
        scan_idx   = 0;
        scan_found = 1'b0;
        if (mode_i) begin
            for (int k = 0; k < N; k++) begin
                scan_idx = int'(rr_ptr_q) + k;
                if (scan_idx >= N) scan_idx = scan_idx - N;
                if (!scan_found && in_valid_i[scan_idx]) begin
                    scan_found       = 1'b1;
                    grant[scan_idx]  = 1'b1;
                    grant_idx        = SELW'(scan_idx);
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (sel_i == SELW'(i) && in_valid_i[i]) begin
                    grant[i]  = 1'b1;
                    grant_idx = SELW'(i);
                end
            end
        end
    end

    assign any_grant  = |grant;
    assign in_ready_o = grant & {N{load}};

    // One-hot AND-OR mux; safe for non-power-of-two N.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) sel_data = sel_data | chan_data[i];
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            if (any_grant) begin
                out_data_d  = sel_data;
                out_chan_d  = grant_idx;
                out_valid_d = 1'b1;
                if (mode_i) begin
                    rr_ptr_d = (grant_idx == SELW'(N-1)) ? '0 : grant_idx + 1'b1;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_chan_o  = out_chan_q;
    assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_mux_nto1_arb.sv
// Directed bench for mux_nto1_arb with WIDTH=32, N=4.
// Each scenario task drives its own stimulus and checks against hand-computed values.
module tb_mux_nto1_arb;

    localparam int WIDTH = 32;
    localparam int N     = 4;
    localparam int SELW  = 2;

    logic               clk;
    logic               rst;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic               mode;
    logic [SELW-1:0]    sel;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_chan;
    logic               out_valid;
    logic               out_ready;

    logic [WIDTH-1:0] chd [N];
    int errors;
    int checks;

    mux_nto1_arb #(.WIDTH(WIDTH), .N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .mode_i      (mode),
        .sel_i       (sel),
        .out_data_o  (out_data),
        .out_chan_o  (out_chan),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        in_data = '0;
        for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = chd[i];
    end

    task automatic step();
        @(posedge clk);
        #1;
        $display("txn t=%0t valid=%0b chan=%0d data=%h", $time, out_valid, out_chan, out_data);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++;
        if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
        checks++;
        if (out_chan !== 2'd0) begin errors++; $display("FAIL reset_chan: got %0d want 0", out_chan); end
        rst = 1'b0;
    endtask

    task automatic test_fixed();
        mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin errors++; $display("FAIL fixed_ready: got %b want 0100", in_ready); end
        step();
        checks++;
        if (out_data !== 32'hDEADBEEF) begin errors++; $display("FAIL fixed_data: got %h want deadbeef", out_data); end
        checks++;
        if (out_chan !== 2'd2) begin errors++; $display("FAIL fixed_chan: got %0d want 2", out_chan); end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL fixed_valid: got %b want 1", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        chd[2] = 32'h12345678;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0000", c, in_ready); end
            checks++;
            if (out_data !== 32'hDEADBEEF || out_valid !== 1'b1) begin
                errors++; $display("FAIL bp_hold[%0d]: got %h/%b want deadbeef/1", c, out_data, out_valid);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin errors++; $display("FAIL bp_refill_ready: got %b want 0100", in_ready); end
        step();
        checks++;
        if (out_data !== 32'h12345678 || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_refill_data: got %h/%b want 12345678/1", out_data, out_valid);
        end
    endtask

    task automatic reset_midstream(input string tag);
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        in_valid = 4'b0000;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_chan !== 2'd0) begin
            errors++;
            $display("FAIL %s: got valid=%b data=%h chan=%0d want 0/0/0", tag, out_valid, out_data, out_chan);
        end
        #2;
        rst = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_rr_wrap();
        logic [1:0] seq_a [6];
        logic [1:0] seq_b [4];
        seq_a = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        seq_b = '{2'd0, 2'd3, 2'd0, 2'd3};
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (out_chan !== seq_a[k] || out_valid !== 1'b1 || out_data !== chd[seq_a[k]]) begin
                errors++;
                $display("FAIL rr_all[%0d]: got chan=%0d valid=%b data=%h want chan=%0d valid=1 data=%h",
                         k, out_chan, out_valid, out_data, seq_a[k], chd[seq_a[k]]);
            end
        end
        reset_midstream("reset_mid_rr");
        in_valid = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (out_chan !== seq_b[k] || out_valid !== 1'b1 || out_data !== chd[seq_b[k]]) begin
                errors++;
                $display("FAIL rr_1001[%0d]: got chan=%0d valid=%b data=%h want chan=%0d",
                         k, out_chan, out_valid, out_data, seq_b[k]);
            end
        end
    endtask

    task automatic test_idle();
        mode = 1'b0; sel = 2'd3; in_valid = 4'b0111; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin errors++; $display("FAIL idle_ready: got %b want 0000", in_ready); end
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b want 0", out_valid); end
        checks++;
        if (out_data !== chd[3] || out_chan !== 2'd3) begin
            errors++; $display("FAIL idle_hold: got %h/%0d want %h/3", out_data, out_chan, chd[3]);
        end
    endtask

    task automatic test_mode_switch();
        logic [1:0] seq [6];
        seq = '{2'd0, 2'd1, 2'd0, 2'd3, 2'd2, 2'd3};
        in_valid = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            case (k)
                0: mode = 1'b1;
                2: begin mode = 1'b0; sel = 2'd0; end
                3: sel = 2'd3;
                4: mode = 1'b1;
                default: ;
            endcase
            step();
            checks++;
            if (out_chan !== seq[k] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL mode_switch[%0d]: got chan=%0d valid=%b want chan=%0d valid=1",
                         k, out_chan, out_valid, seq[k]);
            end
        end
        in_valid = 4'b0000;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
        chd[0] = 32'hA000_0000;
        chd[1] = 32'hA000_0001;
        chd[2] = 32'hDEADBEEF;
        chd[3] = 32'hA000_0003;
        test_reset();
        test_fixed();
        test_backpressure();
        reset_midstream("reset_mid_fixed");
        test_rr_wrap();
        test_idle();
        test_mode_switch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
